// File: rtl/grid_pkg.sv
// Shared types and width helpers for the grid segment checker.
package grid_pkg;

    // Sequencer states for one segment walk.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    // Coordinate width W: the wider of the two grid axes.
    function automatic int coord_w(input int wl, input int hl);
        return (wl > hl) ? wl : hl;
    endfunction

    // Error-term width: W+2 signed bits hold err in [-2^W, 2^W] and e2 = 2*err.
    function automatic int err_w(input int wl, input int hl);
        return coord_w(wl, hl) + 2;
    endfunction

endpackage

// File: rtl/grid_segment_checker_bresenham_step.sv
// One integer Bresenham step: the next cell and error term, plus the end-of-segment flag.
module bresenham_step #(
    parameter int XW = 8,
    parameter int YW = 8,
    parameter int EW = 10
) (
    input  logic [XW-1:0]        x,
    input  logic [YW-1:0]        y,
    input  logic [XW-1:0]        xe,
    input  logic [YW-1:0]        ye,
    input  logic signed [EW-1:0] err,
    input  logic signed [EW-1:0] dx,
    input  logic signed [EW-1:0] dy,
    input  logic                 sx_neg,
    input  logic                 sy_neg,
    output logic [XW-1:0]        x_nxt,
    output logic [YW-1:0]        y_nxt,
    output logic signed [EW-1:0] err_nxt,
    output logic                 at_end
);

    logic signed [EW-1:0] e2;

    // Both axis updates are evaluated against the same e2, so a diagonal move happens in one step.
    always_comb begin
        e2      = err <<< 1;
        x_nxt   = x;
        y_nxt   = y;
        err_nxt = err;
        at_end  = (x == xe) && (y == ye);
        if (e2 >= dy) begin
            err_nxt = err_nxt + dy;
            x_nxt   = sx_neg ? (x - XW'(1)) : (x + XW'(1));
        end
        if (e2 <= dx) begin
            err_nxt = err_nxt + dx;
            y_nxt   = sy_neg ? (y - YW'(1)) : (y + YW'(1));
        end
    end

endmodule

// File: rtl/grid_segment_checker.sv
// Walks a grid segment cell by cell, reading occupancy and stopping at the first occupied cell.
module grid_segment_checker
    import grid_pkg::*;
#(
    parameter int GRID_WIDTH_LOG2  = 8,
    parameter int GRID_HEIGHT_LOG2 = 8
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              req_vld,
    output logic                                              req_rdy,
    input  logic [GRID_WIDTH_LOG2-1:0]                        x0,
    input  logic [GRID_WIDTH_LOG2-1:0]                        x1,
    input  logic [GRID_HEIGHT_LOG2-1:0]                       y0,
    input  logic [GRID_HEIGHT_LOG2-1:0]                       y1,
    output logic                                              res_vld,
    input  logic                                              res_rdy,
    output logic                                              res_collision,
    output logic [coord_w(GRID_WIDTH_LOG2, GRID_HEIGHT_LOG2):0] res_cells,
    output logic [GRID_WIDTH_LOG2-1:0]                        grid_cell_x,
    output logic [GRID_HEIGHT_LOG2-1:0]                       grid_cell_y,
    output logic                                              grid_vld_in,
    input  logic                                              grid_rdy,
    output logic                                              grid_we,
    output logic                                              grid_w_occupied,
    input  logic                                              grid_vld_out,
    input  logic                                              grid_r_occupied
);

    localparam int XW = GRID_WIDTH_LOG2;
    localparam int YW = GRID_HEIGHT_LOG2;
    localparam int W  = coord_w(GRID_WIDTH_LOG2, GRID_HEIGHT_LOG2);
    localparam int EW = err_w(GRID_WIDTH_LOG2, GRID_HEIGHT_LOG2);

    state_t state, state_nxt;

    logic [XW-1:0]        x, xe, x_step;
    logic [YW-1:0]        y, ye, y_step;
    logic signed [EW-1:0] dx, dy, err, err_step;
    logic                 sx_neg, sy_neg;
    logic [W:0]           cnt;
    logic                 collision;
    logic                 at_end;

    logic                 accept, issue_fire, rsp;
    logic [XW-1:0]        adx;
    logic [YW-1:0]        ady;
    logic signed [EW-1:0] dx_init, dy_init;

    assign accept     = (state == IDLE) && req_vld;
    assign issue_fire = (state == ISSUE) && grid_rdy;
    assign rsp        = (state == WAIT) && grid_vld_out;

    // Segment deltas in the signed error domain: dx >= 0, dy <= 0.
    assign adx     = (x1 > x0) ? (x1 - x0) : (x0 - x1);
    assign ady     = (y1 > y0) ? (y1 - y0) : (y0 - y1);
    assign dx_init = $signed({{(EW-XW){1'b0}}, adx});
    assign dy_init = -$signed({{(EW-YW){1'b0}}, ady});

    bresenham_step #(
        .XW(XW),
        .YW(YW),
        .EW(EW)
    ) u_step (
        .x       (x),
        .y       (y),
        .xe      (xe),
        .ye      (ye),
        .err     (err),
        .dx      (dx),
        .dy      (dy),
        .sx_neg  (sx_neg),
        .sy_neg  (sy_neg),
        .x_nxt   (x_step),
        .y_nxt   (y_step),
        .err_nxt (err_step),
        .at_end  (at_end)
    );

    // State register; reset abandons any walk in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one read outstanding at a time, step straight back to ISSUE after a free cell.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_vld)      state_nxt = ISSUE;
            ISSUE:   if (grid_rdy)     state_nxt = WAIT;
            WAIT:    if (grid_vld_out) state_nxt = (grid_r_occupied || at_end) ? DONE : ISSUE;
            DONE:    if (res_rdy)      state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Current cell, cell count and hit flag; these feed outputs so they carry reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            cnt       <= '0;
            collision <= 1'b0;
        end else if (accept) begin
            x         <= x0;
            y         <= y0;
            cnt       <= '0;
            collision <= 1'b0;
        end else if (issue_fire) begin
            cnt <= cnt + (W+1)'(1);
        end else if (rsp) begin
            if (grid_r_occupied) begin
                collision <= 1'b1;
            end else if (!at_end) begin
                x <= x_step;
                y <= y_step;
            end
        end
    end

    // Segment constants and the running error term; only meaningful once a request is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            xe     <= x1;
            ye     <= y1;
            dx     <= dx_init;
            dy     <= dy_init;
            sx_neg <= !(x1 > x0);
            sy_neg <= !(y1 > y0);
            err    <= dx_init + dy_init;
        end else if (rsp && !grid_r_occupied && !at_end) begin
            err <= err_step;
        end
    end

    assign req_rdy         = (state == IDLE);
    assign res_vld         = (state == DONE);
    assign res_collision   = (state == DONE) && collision;
    assign res_cells       = (state == DONE) ? cnt : '0;
    assign grid_vld_in     = (state == ISSUE);
    assign grid_cell_x     = x;
    assign grid_cell_y     = y;
    assign grid_we         = 1'b0;
    assign grid_w_occupied = 1'b0;

endmodule

// File: tb/tb_grid_segment_checker.sv
// Directed bench for grid_segment_checker on a 16x16 grid with a behavioural occupancy grid.
module tb_grid_segment_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_vld = 1'b0;
    logic       req_rdy;
    logic [3:0] x0 = '0, x1 = '0, y0 = '0, y1 = '0;
    logic       res_vld;
    logic       res_rdy = 1'b0;
    logic       res_collision;
    logic [4:0] res_cells;
    logic [3:0] grid_cell_x, grid_cell_y;
    logic       grid_vld_in;
    logic       grid_rdy;
    logic       grid_we, grid_w_occupied;
    logic       grid_vld_out = 1'b0;
    logic       grid_r_occupied = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    bit stall = 1'b0;
    int lat = 1;
    bit occ [0:15][0:15];
    int rd_log[$];
    bit pend = 1'b0;
    int pcnt = 0;
    bit rsp_occ = 1'b0;

    grid_segment_checker #(
        .GRID_WIDTH_LOG2 (4),
        .GRID_HEIGHT_LOG2(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .x0             (x0),
        .x1             (x1),
        .y0             (y0),
        .y1             (y1),
        .res_vld        (res_vld),
        .res_rdy        (res_rdy),
        .res_collision  (res_collision),
        .res_cells      (res_cells),
        .grid_cell_x    (grid_cell_x),
        .grid_cell_y    (grid_cell_y),
        .grid_vld_in    (grid_vld_in),
        .grid_rdy       (grid_rdy),
        .grid_we        (grid_we),
        .grid_w_occupied(grid_w_occupied),
        .grid_vld_out   (grid_vld_out),
        .grid_r_occupied(grid_r_occupied)
    );

    always #5 clk = ~clk;

    assign grid_rdy = !stall;

    // Occupancy grid model: logs every accepted read and answers after 'lat' extra cycles.
    // It ignores rst_n so a read in flight across a DUT reset still produces its late response.
    always @(posedge clk) begin
        grid_vld_out <= 1'b0;
        if (pend) begin
            if (pcnt == 0) begin
                grid_vld_out    <= 1'b1;
                grid_r_occupied <= rsp_occ;
                pend            <= 1'b0;
            end else begin
                pcnt <= pcnt - 1;
            end
        end
        if (grid_vld_in && grid_rdy) begin
            pend    <= 1'b1;
            pcnt    <= lat;
            rsp_occ <= occ[grid_cell_x][grid_cell_y];
            rd_log.push_back(int'(grid_cell_x) * 16 + int'(grid_cell_y));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_read(input string tag, input int idx, input int ex, input int ey);
        logic [32:0] v;
        v = (idx < rd_log.size()) ? {1'b0, 32'(rd_log[idx])} : 33'h1_FFFF_FFFF;
        chk(tag, v[31:0], 32'(ex * 16 + ey));
    endtask

    task automatic start_req(input int ax0, input int ay0, input int ax1, input int ay1);
        @(negedge clk);
        x0 = 4'(ax0);
        y0 = 4'(ay0);
        x1 = 4'(ax1);
        y1 = 4'(ay1);
        req_vld = 1'b1;
        @(negedge clk);
        req_vld = 1'b0;
        x0 = '0;
        y0 = '0;
        x1 = '0;
        y1 = '0;
    endtask

    task automatic wait_res();
        int n;
        n = 0;
        while (!res_vld && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("res_timeout", 32'(res_vld), 32'd1);
    endtask

    task automatic ack_res();
        res_rdy = 1'b1;
        @(negedge clk);
        res_rdy = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_rdy"}, 32'(req_rdy), 32'd1);
        chk({tag, "_res_vld"}, 32'(res_vld), 32'd0);
        chk({tag, "_res_coll"}, 32'(res_collision), 32'd0);
        chk({tag, "_res_cells"}, 32'(res_cells), 32'd0);
        chk({tag, "_vld_in"}, 32'(grid_vld_in), 32'd0);
        chk({tag, "_cell_x"}, 32'(grid_cell_x), 32'd0);
        chk({tag, "_cell_y"}, 32'(grid_cell_y), 32'd0);
    endtask

    initial begin
        int steep_x[7];
        int steep_y[7];
        int n;
        steep_x = '{3, 3, 2, 2, 2, 1, 1};
        steep_y = '{10, 9, 8, 7, 6, 5, 4};

        // Reset state, both while held and just after release.
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");
        chk("rst_we", 32'(grid_we), 32'd0);
        chk("rst_wocc", 32'(grid_w_occupied), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_rst");

        // Horizontal run on an empty grid.
        rd_log.delete();
        start_req(0, 0, 3, 0);
        wait_res();
        chk("h_coll", 32'(res_collision), 32'd0);
        chk("h_cells", 32'(res_cells), 32'd4);
        chk("h_nreads", 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_read("h_read", i, i, 0);
        ack_res();
        chk("h_ack_vld", 32'(res_vld), 32'd0);
        chk("h_ack_rdy", 32'(req_rdy), 32'd1);

        // Diagonal stopping at the occupied cell (2,2).
        occ[2][2] = 1'b1;
        rd_log.delete();
        start_req(0, 0, 5, 5);
        wait_res();
        chk("d_coll", 32'(res_collision), 32'd1);
        chk("d_cells", 32'(res_cells), 32'd3);
        repeat (4) @(negedge clk);
        chk("d_nreads", 32'(rd_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk_read("d_read", i, i, i);
        ack_res();
        occ[2][2] = 1'b0;

        // Zero-length segment, free then occupied.
        rd_log.delete();
        start_req(7, 7, 7, 7);
        wait_res();
        chk("z_free_coll", 32'(res_collision), 32'd0);
        chk("z_free_cells", 32'(res_cells), 32'd1);
        chk_read("z_free_read", 0, 7, 7);
        ack_res();
        occ[7][7] = 1'b1;
        start_req(7, 7, 7, 7);
        wait_res();
        chk("z_occ_coll", 32'(res_collision), 32'd1);
        chk("z_occ_cells", 32'(res_cells), 32'd1);
        ack_res();
        occ[7][7] = 1'b0;

        // Steep segment with both steps negative.
        rd_log.delete();
        start_req(3, 10, 1, 4);
        wait_res();
        chk("s_coll", 32'(res_collision), 32'd0);
        chk("s_cells", 32'(res_cells), 32'd7);
        chk("s_nreads", 32'(rd_log.size()), 32'd7);
        for (int i = 0; i < 7; i++) chk_read("s_read", i, steep_x[i], steep_y[i]);
        ack_res();

        // Read-side stall: request held stable, no read taken while grid_rdy is low.
        rd_log.delete();
        stall = 1'b1;
        start_req(4, 5, 6, 5);
        for (int i = 0; i < 5; i++) begin
            chk("st_vld_in", 32'(grid_vld_in), 32'd1);
            chk("st_cell_x", 32'(grid_cell_x), 32'd4);
            chk("st_cell_y", 32'(grid_cell_y), 32'd5);
            chk("st_noread", 32'(rd_log.size()), 32'd0);
            @(negedge clk);
        end
        stall = 1'b0;
        wait_res();
        chk("st_cells", 32'(res_cells), 32'd3);
        chk("st_nreads", 32'(rd_log.size()), 32'd3);
        chk_read("st_read0", 0, 4, 5);
        chk_read("st_read1", 1, 5, 5);
        chk_read("st_read2", 2, 6, 5);

        // Result-side stall: result held and no new request accepted.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rs_vld", 32'(res_vld), 32'd1);
            chk("rs_cells", 32'(res_cells), 32'd3);
            chk("rs_coll", 32'(res_collision), 32'd0);
            chk("rs_req_rdy", 32'(req_rdy), 32'd0);
        end
        ack_res();
        chk("rs_ack_vld", 32'(res_vld), 32'd0);
        chk("rs_ack_rdy", 32'(req_rdy), 32'd1);

        // Reset while a read is outstanding; its late response must be ignored.
        lat = 10;
        rd_log.delete();
        start_req(0, 0, 15, 0);
        n = 0;
        while (rd_log.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mr_issued", 32'(rd_log.size()), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mr_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk_reset_outputs("mr_late");
        chk("mr_nreads", 32'(rd_log.size()), 32'd1);
        lat = 1;
        rd_log.delete();
        start_req(0, 0, 1, 0);
        wait_res();
        chk("mr_coll", 32'(res_collision), 32'd0);
        chk("mr_cells", 32'(res_cells), 32'd2);
        chk("mr_nreads2", 32'(rd_log.size()), 32'd2);
        ack_res();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
